// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS data-memory port.
// Access sizes, responder FSM states and byte-lane masks.
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    unique case (size)
      SIZE_BYTE: lane_mask = MASK_BYTE << off;
      SIZE_HALF: lane_mask = MASK_HALF << {off[1], 1'b0};
      SIZE_WORD: lane_mask = MASK_WORD;
      default:   lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load extraction: picks the addressed byte/half/word
// out of a little-endian word and sign/zero-extends it.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    unique case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = offset[1] ? word[31:16] : word[15:0];
    data = '0;
    unique case (size)
      SIZE_BYTE: data = {{24{b[7] & ~zext}}, b};
      SIZE_HALF: data = {{16{h[15] & ~zext}}, h};
      SIZE_WORD: data = word;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store,
// programmable wait cycles, registered response.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [29:0] LIMIT = 30'(DEPTH);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  state_t state, state_n;
  logic [3:0]  cnt;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] mem [DEPTH];

  logic          accept, commit, err;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word, ld_data, wd_lanes;
  logic [3:0]    mask;

  assign accept  = req_valid && req_ready;
  assign commit  = (state == WAIT) && (cnt == 4'd0);
  assign idx     = addr_q[AW+1:2];
  assign rd_word = mem[idx];
  assign mask    = lane_mask(size_q, addr_q[1:0]);

  assign err = (size_q == 2'd3)
    || (size_q == SIZE_HALF && addr_q[0])
    || (size_q == SIZE_WORD && addr_q[1:0] != 2'b00)
    || (addr_q[31:2] >= LIMIT);

  always_comb begin
    unique case (size_q)
      SIZE_BYTE: wd_lanes = {4{wdata_q[7:0]}};
      SIZE_HALF: wd_lanes = {2{wdata_q[15:0]}};
      default:   wd_lanes = wdata_q;
    endcase
  end

  load_align u_align (
    .word   (rd_word),
    .offset (addr_q[1:0]),
    .size   (size_q),
    .zext   (uns_q),
    .data   (ld_data)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // WAIT always runs at least one cycle so the commit
  // works from latched request fields.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = WAIT;
      WAIT:    if (cnt == 4'd0) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= LAT;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_error <= err;
        rsp_rdata <= (we_q || err) ? 32'd0 : ld_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && commit && we_q && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (mask[k]) mem[idx][8*k +: 8] <= wd_lanes[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases plus
// random traffic against a behavioural memory model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic        z_req_we = 1'b0;
  logic [31:0] z_req_addr = '0;
  logic [1:0]  z_req_size = '0;
  logic        z_req_unsigned = 1'b0;
  logic [31:0] z_req_wdata = '0;
  logic        z_rsp_valid;
  logic        z_rsp_ready = 1'b1;
  logic [31:0] z_rsp_rdata;
  logic        z_rsp_error;

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(0)) u_lat0 (
    .clock(clock), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_addr(z_req_addr),
    .req_size(z_req_size), .req_unsigned(z_req_unsigned),
    .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_error(z_rsp_error)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [64];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          mode = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // mode 0: random ready, 1: stall, 2: always ready
  always @(posedge clock) begin
    #1;
    case (mode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic logic ref_err(input logic [31:0] a,
                                   input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0)
      || (sz == 2'd2 && a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w,
                                           input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input logic uns);
    logic [31:0] v;
    v = w;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w,
                                            input logic [31:0] a,
                                            input logic [1:0] sz,
                                            input logic [31:0] wd);
    logic [31:0] m;
    int sh;
    if (sz == 2'd2) return wd;
    sh = (sz == 2'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
    m = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~m) | ((wd << sh) & m);
  endfunction

  // Monitor: latency, hold stability and scoreboard pop.
  logic        prev_hold = 1'b0;
  logic        seen = 1'b0;
  logic [31:0] prev_rd = '0;
  logic        prev_err = 1'b0;
  exp_t        e_m;

  always @(negedge clock) begin
    if (reset) begin
      prev_hold = 1'b0;
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (prev_hold) begin
        check("hold_rdata", rsp_rdata, prev_rd);
        check("hold_error", 32'(rsp_error), 32'(prev_err));
      end
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rsp: got response %h, required none",
                 rsp_rdata);
        seen = 1'b1;
      end else if (!seen) begin
        seen = 1'b1;
        check("latency", 32'(cyc - exp_q[0].acc), 32'(LAT + 1));
      end
      if (rsp_ready) begin
        if (exp_q.size() != 0) begin
          e_m = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e_m.rd);
          check("rsp_error", 32'(rsp_error), 32'(e_m.err));
        end
        seen = 1'b0;
        prev_hold = 1'b0;
      end else begin
        prev_hold = 1'b1;
        prev_rd = rsp_rdata;
        prev_err = rsp_error;
      end
    end else begin
      prev_hold = 1'b0;
      seen = 1'b0;
    end
  end

  // Called at a negedge; returns at a negedge after accept.
  task automatic do_req(input logic we, input logic [31:0] a,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] wd, input bit use_k,
                        input logic [31:0] k_rd, input logic k_err);
    exp_t e;
    int   n;
    n = 0;
    req_we = we; req_addr = a; req_size = sz;
    req_unsigned = uns; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++;
      $display("FAIL req_timeout: got req_ready=0, required 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    e.err = ref_err(a, sz);
    e.rd = (we || e.err) ? 32'd0 : ref_load(mem_m[a / 4], a, sz, uns);
    if (we && !e.err) mem_m[a / 4] = ref_store(mem_m[a / 4], a, sz, wd);
    if (use_k) begin
      e.rd = k_rd;
      e.err = k_err;
    end
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0 || rsp_valid) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending, required 0",
               exp_q.size());
    end
  endtask

  task automatic z_req(input logic we, input logic [31:0] a,
                       input logic [1:0] sz, input logic uns,
                       input logic [31:0] wd, input logic [31:0] x_rd,
                       input logic x_err);
    z_req_we = we; z_req_addr = a; z_req_size = sz;
    z_req_unsigned = uns; z_req_wdata = wd; z_req_valid = 1'b1;
    check("lat0_req_ready", 32'(z_req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    z_req_valid = 1'b0;
    check("lat0_not_yet", 32'(z_rsp_valid), 32'd0);
    @(negedge clock);
    check("lat0_valid", 32'(z_rsp_valid), 32'd1);
    check("lat0_rdata", z_rsp_rdata, x_rd);
    check("lat0_error", 32'(z_rsp_error), 32'(x_err));
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    repeat (3) @(negedge clock);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_error", 32'(rsp_error), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 64; i++)
      do_req(1'b1, 32'(i * 4), 2'd2, 1'b0, $urandom, 1'b0, '0, 1'b0);

    do_req(1, 32'h10, 2, 0, 32'hDEADBEEF, 1, 32'h0, 0);
    do_req(0, 32'h10, 2, 0, 32'h0, 1, 32'hDEADBEEF, 0);
    do_req(1, 32'h20, 2, 0, 32'h80FF7F01, 1, 32'h0, 0);
    do_req(0, 32'h23, 0, 0, 32'h0, 1, 32'hFFFFFF80, 0);
    do_req(0, 32'h23, 0, 1, 32'h0, 1, 32'h00000080, 0);
    do_req(0, 32'h22, 1, 0, 32'h0, 1, 32'hFFFF80FF, 0);
    do_req(0, 32'h20, 1, 1, 32'h0, 1, 32'h00007F01, 0);
    do_req(1, 32'h30, 2, 0, 32'h11223344, 1, 32'h0, 0);
    do_req(1, 32'h31, 0, 0, 32'h000000AA, 1, 32'h0, 0);
    do_req(0, 32'h30, 2, 0, 32'h0, 1, 32'h1122AA44, 0);
    do_req(1, 32'h32, 1, 0, 32'h0000BEEF, 1, 32'h0, 0);
    do_req(0, 32'h30, 2, 0, 32'h0, 1, 32'hBEEFAA44, 0);

    do_req(1, 32'h40, 2, 0, 32'h0BADF00D, 1, 32'h0, 0);
    do_req(1, 32'h00, 2, 0, 32'h01020304, 1, 32'h0, 0);
    do_req(0, 32'h42, 2, 0, 32'h0, 1, 32'h0, 1);
    do_req(0, 32'h41, 1, 0, 32'h0, 1, 32'h0, 1);
    do_req(0, 32'h40, 3, 0, 32'h0, 1, 32'h0, 1);
    do_req(1, 32'h42, 2, 0, 32'hFFFFFFFF, 1, 32'h0, 1);
    do_req(1, 32'h40, 3, 0, 32'hFFFFFFFF, 1, 32'h0, 1);
    do_req(1, 32'(4 * DEPTH), 2, 0, 32'hFFFFFFFF, 1, 32'h0, 1);
    do_req(0, 32'h40, 2, 0, 32'h0, 1, 32'h0BADF00D, 0);
    do_req(0, 32'h00, 2, 0, 32'h0, 1, 32'h01020304, 0);
    drain();

    mode = 1;
    @(negedge clock);
    do_req(0, 32'h40, 2, 0, 32'h0, 1, 32'h0BADF00D, 0);
    req_we = 1'b1; req_addr = 32'h40; req_size = 2'd2;
    req_wdata = 32'hBAD0BAD0; req_valid = 1'b1;
    r = 0;
    while (!rsp_valid && r < 50) begin
      @(negedge clock);
      r++;
    end
    check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (5) begin
      @(negedge clock);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    req_valid = 1'b0;
    mode = 2;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("release_req_ready", 32'(req_ready), 32'd1);
    check("release_rsp_valid", 32'(rsp_valid), 32'd0);
    do_req(0, 32'h40, 2, 0, 32'h0, 1, 32'h0BADF00D, 0);
    drain();
    mode = 0;

    do_req(1, 32'h50, 2, 0, 32'h0, 1, 32'h0, 0);
    do_req(0, 32'h10, 2, 0, 32'h0, 1, 32'hDEADBEEF, 0);
    drain();
    req_we = 1'b1; req_addr = 32'h50; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h12345678; req_valid = 1'b1;
    r = 0;
    while (!req_ready && r < 50) begin
      @(negedge clock);
      r++;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("midreset_req_ready", 32'(req_ready), 32'd1);
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_rsp_rdata", rsp_rdata, 32'd0);
    check("midreset_rsp_error", 32'(rsp_error), 32'd0);
    do_req(0, 32'h50, 2, 0, 32'h0, 1, 32'h0, 0);
    drain();

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
      else if (r == 1) a = $urandom | 32'h1000_0000;
      else a = 32'($urandom_range(0, 255));
      do_req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, 1'b0, '0, 1'b0);
    end
    drain();

    z_req(1, 32'h4, 2, 0, 32'hCAFEF00D, 32'h0, 0);
    z_req(0, 32'h4, 2, 0, 32'h0, 32'hCAFEF00D, 0);
    z_req(0, 32'h7, 0, 1, 32'h0, 32'h000000CA, 0);
    z_req(0, 32'h40, 2, 0, 32'h0, 32'h0, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
